// File: rtl/read_test_sequencer_pkg.sv
// Shared definitions for the read test sequencer: state encoding, default
// timing parameters and small state-decode helpers.
package read_test_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FLUSH = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int unsigned DEF_FLUSH_CYCLES = 4;
  localparam int unsigned DEF_GEN_LATENCY  = 1;
  localparam int unsigned WORD_W           = 32;
  localparam int unsigned CLK_CNT_W        = 64;

  function automatic logic is_busy(input state_t s);
    return (s == ST_FLUSH) || (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

  // Cycles in these states are accumulated into clk_counts.
  function automatic logic is_timed(input state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/read_test_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/read_test_sequencer.sv
// Sequences one pipe-out read test: flush generator/FIFO, issue cfg words,
// wait for the host to drain them, and keep run statistics for readback.
//
// state | meaning
// IDLE  | waiting for start, statistics held from the last run
// FLUSH | generator and FIFO held in reset for FLUSH_CYCLES cycles
// RUN   | issuing gen_enable pulses until cfg words are requested
// DRAIN | waiting until every word is written and read back
// DONE  | run complete, statistics held until the next start
module read_test_sequencer
  import read_test_sequencer_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES,
  parameter int unsigned GEN_LATENCY  = DEF_GEN_LATENCY
) (
  input  logic                 okClk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [WORD_W-1:0]    word_count_cfg_i,
  input  logic                 fifo_almost_full_i,
  input  logic                 fifo_empty_i,
  input  logic                 pipe_read_i,
  input  logic                 gen_valid_i,
  output logic                 gen_enable_o,
  output logic                 gen_reset_o,
  output logic [CLK_CNT_W-1:0] clk_counts_o,
  output logic [WORD_W-1:0]    words_written_o,
  output logic [WORD_W-1:0]    words_read_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 underrun_err_o
);

  localparam int unsigned FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1) begin : g_bad_flush
    $error("FLUSH_CYCLES must be at least 1");
  end
  if (GEN_LATENCY < 1) begin : g_bad_latency
    $error("GEN_LATENCY must be at least 1");
  end

  state_t              state_q;
  state_t              state_d;
  logic [WORD_W-1:0]   cfg_q;
  logic [FLUSH_W-1:0]  flush_cnt_q;
  logic                underrun_q;
  logic                busy_q;
  logic                done_q;
  logic                gen_reset_q;

  logic                start_acc;
  logic                cnt_en;
  logic                gen_enable;
  logic [WORD_W-1:0]   issued;
  logic [WORD_W-1:0]   words_written;
  logic [WORD_W-1:0]   words_read;
  logic [CLK_CNT_W-1:0] clk_counts;

  assign start_acc = start_i & ~abort_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  // Abort freezes statistics on the cycle it is seen, so readback shows the pre-abort values.
  assign cnt_en    = is_busy(state_q) & ~abort_i;
  assign gen_enable = (state_q == ST_RUN) & ~fifo_almost_full_i & (issued < cfg_q);

  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) state_d = ST_FLUSH;
        end
        ST_FLUSH: begin
          if (flush_cnt_q == '0) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (issued == cfg_q) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if ((words_written == cfg_q) && (words_read == cfg_q)) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge okClk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      cfg_q       <= '0;
      flush_cnt_q <= '0;
      underrun_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      gen_reset_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= is_busy(state_d);
      done_q      <= (state_d == ST_DONE);
      gen_reset_q <= (state_d == ST_FLUSH);
      if (start_acc) begin
        cfg_q       <= word_count_cfg_i;
        flush_cnt_q <= FLUSH_LOAD;
        underrun_q  <= 1'b0;
      end else begin
        if ((state_q == ST_FLUSH) && (flush_cnt_q != '0)) begin
          flush_cnt_q <= flush_cnt_q - FLUSH_W'(1);
        end
        if (cnt_en && pipe_read_i && fifo_empty_i) begin
          underrun_q <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.WIDTH(CLK_CNT_W)) u_clk_counts (
    .clk_i   (okClk_i),
    .rst_i   (reset_i),
    .clr_i   (start_acc),
    .inc_i   (cnt_en & is_timed(state_q)),
    .count_o (clk_counts)
  );

  sat_counter #(.WIDTH(WORD_W)) u_words_written (
    .clk_i   (okClk_i),
    .rst_i   (reset_i),
    .clr_i   (start_acc),
    .inc_i   (cnt_en & gen_valid_i),
    .count_o (words_written)
  );

  sat_counter #(.WIDTH(WORD_W)) u_words_read (
    .clk_i   (okClk_i),
    .rst_i   (reset_i),
    .clr_i   (start_acc),
    .inc_i   (cnt_en & pipe_read_i),
    .count_o (words_read)
  );

  sat_counter #(.WIDTH(WORD_W)) u_issued (
    .clk_i   (okClk_i),
    .rst_i   (reset_i),
    .clr_i   (start_acc),
    .inc_i   (gen_enable),
    .count_o (issued)
  );

  assign gen_enable_o    = gen_enable;
  assign gen_reset_o     = gen_reset_q;
  assign clk_counts_o    = clk_counts;
  assign words_written_o = words_written;
  assign words_read_o    = words_read;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign underrun_err_o  = underrun_q;

endmodule

// File: tb/tb_read_test_sequencer.sv
// Bench for read_test_sequencer: directed runs against a behavioural run model
// with a generator/FIFO/host emulation around the DUT.
module tb_read_test_sequencer;

  localparam int unsigned FLUSH_CYCLES = 4;

  logic        okClk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] word_count_cfg_i = '0;
  logic        fifo_almost_full_i = 1'b0;
  logic        fifo_empty_i = 1'b1;
  logic        pipe_read_i = 1'b0;
  logic        gen_valid_i = 1'b0;
  logic        gen_enable_o;
  logic        gen_reset_o;
  logic [63:0] clk_counts_o;
  logic [31:0] words_written_o;
  logic [31:0] words_read_o;
  logic        busy_o;
  logic        done_o;
  logic        underrun_err_o;

  read_test_sequencer #(.FLUSH_CYCLES(FLUSH_CYCLES), .GEN_LATENCY(1)) dut (
    .okClk_i            (okClk_i),
    .reset_i            (reset_i),
    .start_i            (start_i),
    .abort_i            (abort_i),
    .word_count_cfg_i   (word_count_cfg_i),
    .fifo_almost_full_i (fifo_almost_full_i),
    .fifo_empty_i       (fifo_empty_i),
    .pipe_read_i        (pipe_read_i),
    .gen_valid_i        (gen_valid_i),
    .gen_enable_o       (gen_enable_o),
    .gen_reset_o        (gen_reset_o),
    .clk_counts_o       (clk_counts_o),
    .words_written_o    (words_written_o),
    .words_read_o       (words_read_o),
    .busy_o             (busy_o),
    .done_o             (done_o),
    .underrun_err_o     (underrun_err_o)
  );

  initial forever #5 okClk_i = ~okClk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural run model ----------------
  typedef enum {P_IDLE, P_FLUSH, P_RUN, P_DRAIN, P_DONE} phase_e;
  phase_e      m_phase = P_IDLE;
  phase_e      m_prev;
  logic [31:0] m_cfg = '0, m_issued = '0, m_wr = '0, m_rd = '0;
  logic [63:0] m_clk = '0;
  logic        m_under = 1'b0;
  int          m_flush = 0;
  logic        m_busy, m_en;

  initial forever begin
    @(posedge okClk_i or posedge reset_i);
    if (reset_i) begin
      m_phase = P_IDLE; m_cfg = '0; m_issued = '0; m_wr = '0; m_rd = '0;
      m_clk = '0; m_under = 1'b0; m_flush = 0;
    end else begin
      m_prev = m_phase;
      m_busy = (m_prev == P_FLUSH) || (m_prev == P_RUN) || (m_prev == P_DRAIN);
      m_en   = (m_prev == P_RUN) && !fifo_almost_full_i && (m_issued < m_cfg);
      if (abort_i) begin
        m_phase = P_IDLE;
      end else begin
        case (m_prev)
          P_IDLE, P_DONE: if (start_i) begin
            m_cfg = word_count_cfg_i; m_issued = '0; m_wr = '0; m_rd = '0;
            m_clk = '0; m_under = 1'b0; m_flush = 0; m_phase = P_FLUSH;
          end
          P_FLUSH: begin
            m_flush++;
            if (m_flush >= FLUSH_CYCLES) m_phase = P_RUN;
          end
          P_RUN:   if (m_issued == m_cfg) m_phase = P_DRAIN;
          P_DRAIN: if (m_wr == m_cfg && m_rd == m_cfg) m_phase = P_DONE;
          default: ;
        endcase
        if (m_busy) begin
          if (gen_valid_i && m_wr != 32'hFFFF_FFFF) m_wr = m_wr + 1;
          if (pipe_read_i && m_rd != 32'hFFFF_FFFF) m_rd = m_rd + 1;
          if (pipe_read_i && fifo_empty_i) m_under = 1'b1;
          if ((m_prev == P_RUN || m_prev == P_DRAIN) && m_clk != '1) m_clk = m_clk + 1;
        end
        if (m_en) m_issued = m_issued + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic cmp_on = 1'b0;
  initial forever begin
    @(negedge okClk_i);
    if (cmp_on) begin
      chk("gen_enable", gen_enable_o,
          (m_phase == P_RUN) && !fifo_almost_full_i && (m_issued < m_cfg));
      chk("gen_reset", gen_reset_o, m_phase == P_FLUSH);
      chk("busy", busy_o, m_phase == P_FLUSH || m_phase == P_RUN || m_phase == P_DRAIN);
      chk("done", done_o, m_phase == P_DONE);
      chk("clk_counts", clk_counts_o, m_clk);
      chk("words_written", words_written_o, m_wr);
      chk("words_read", words_read_o, m_rd);
      chk("underrun_err", underrun_err_o, m_under);
    end
  end

  // ---------------- generator / FIFO / host emulation ----------------
  int level = 0, host_reads = 0, host_target = 0, en_total = 0, flush_seen = 0;

  task automatic step();
    logic en, gv, pr, gr;
    @(negedge okClk_i);
    en = gen_enable_o; gv = gen_valid_i; pr = pipe_read_i; gr = gen_reset_o;
    if (en) en_total++;
    if (gr) flush_seen++;
    @(posedge okClk_i);
    #1;
    start_i = 1'b0;
    abort_i = 1'b0;
    if (gr) level = 0;
    else begin
      if (gv) level++;
      if (pr && level > 0) level--;
    end
    gen_valid_i = en;
    pipe_read_i = (level > 0) && (host_reads < host_target);
    if (pipe_read_i) host_reads++;
    fifo_empty_i = (level == 0);
  endtask

  task automatic do_start(input logic [31:0] cfg);
    word_count_cfg_i = cfg;
    start_i = 1'b1;
    host_reads = 0; host_target = int'(cfg); en_total = 0; flush_seen = 0;
    step();
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (!done_o && n < limit) begin step(); n++; end
    chk({tag, " done reached"}, done_o, 1);
  endtask

  logic [63:0] clk_nostall, clk_stall;
  logic [31:0] ww_hold, wr_hold;
  logic [63:0] clk_hold;
  int          en_before, n;

  initial begin
    repeat (2) @(posedge okClk_i);
    #1;
    chk("reset busy", busy_o, 0);
    chk("reset done", done_o, 0);
    chk("reset clk_counts", clk_counts_o, 0);
    reset_i = 1'b0;
    cmp_on = 1'b1;
    step();

    // cfg=16, no stall; a start pulse while busy must be ignored
    do_start(32'd16);
    repeat (3) step();
    word_count_cfg_i = 32'd5; start_i = 1'b1;
    step();
    wait_done("cfg16", 200);
    chk("cfg16 enables", en_total, 16);
    chk("cfg16 written", words_written_o, 16);
    chk("cfg16 read", words_read_o, 16);
    chk("cfg16 underrun", underrun_err_o, 0);

    // cfg=0: flush only, then straight through RUN and DRAIN
    do_start(32'd0);
    n = 1;
    while (!done_o && n < 20) begin step(); n++; end
    chk("cfg0 done within 7", (n <= 7), 1);
    chk("cfg0 flush cycles", flush_seen, 4);
    chk("cfg0 enables", en_total, 0);
    chk("cfg0 clk_counts", clk_counts_o, 2);

    // cfg=100 without and with a 10-cycle almost_full stall
    do_start(32'd100);
    wait_done("cfg100", 400);
    clk_nostall = clk_counts_o;
    do_start(32'd100);
    repeat (30) step();
    fifo_almost_full_i = 1'b1;
    en_before = en_total;
    repeat (10) step();
    chk("stall enables", en_total - en_before, 0);
    fifo_almost_full_i = 1'b0;
    wait_done("cfg100 stall", 400);
    clk_stall = clk_counts_o;
    chk("stall total enables", en_total, 100);
    chk("stall clk delta", clk_stall - clk_nostall, 10);

    // underrun: one read of an empty FIFO during FLUSH
    do_start(32'd8);
    step();
    pipe_read_i = 1'b1; fifo_empty_i = 1'b1; host_reads++;
    step();
    chk("underrun set", underrun_err_o, 1);
    wait_done("underrun", 200);
    chk("underrun sticky", underrun_err_o, 1);
    chk("underrun read count", words_read_o, 8);
    do_start(32'd8);
    chk("underrun cleared", underrun_err_o, 0);
    wait_done("after underrun", 200);

    // abort in RUN once 5 enables have gone out
    do_start(32'd20);
    n = 0;
    while (en_total < 5 && n < 50) begin step(); n++; end
    chk("abort reached 5 enables", en_total, 5);
    ww_hold = words_written_o; wr_hold = words_read_o; clk_hold = clk_counts_o;
    abort_i = 1'b1;
    step();
    chk("abort busy", busy_o, 0);
    chk("abort gen_enable", gen_enable_o, 0);
    chk("abort written held", words_written_o, ww_hold);
    repeat (3) step();
    chk("abort read held", words_read_o, wr_hold);
    chk("abort clk held", clk_counts_o, clk_hold);
    start_i = 1'b1; abort_i = 1'b1;
    step();
    chk("abort+start busy", busy_o, 0);
    chk("abort+start written", words_written_o, ww_hold);
    level = 0;
    do_start(32'd20);
    chk("restart written cleared", words_written_o, 0);
    chk("restart clk cleared", clk_counts_o, 0);
    wait_done("restart", 200);

    // asynchronous reset in DRAIN
    do_start(32'd16);
    n = 0;
    while (m_phase != P_DRAIN && n < 200) begin step(); n++; end
    chk("reached drain", (m_phase == P_DRAIN), 1);
    #2 reset_i = 1'b1;
    #1;
    chk("arst gen_enable", gen_enable_o, 0);
    chk("arst gen_reset", gen_reset_o, 0);
    chk("arst busy", busy_o, 0);
    chk("arst done", done_o, 0);
    chk("arst clk_counts", clk_counts_o, 0);
    chk("arst written", words_written_o, 0);
    chk("arst read", words_read_o, 0);
    chk("arst underrun", underrun_err_o, 0);
    step();
    step();
    reset_i = 1'b0;
    level = 0;
    step();
    do_start(32'd3);
    wait_done("post reset", 100);
    chk("post reset written", words_written_o, 3);

    cmp_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
